// File: rtl/aes_block_packer_if.sv
// rtl/aes_block_packer_if.sv - byte stream, key load and packed block bundle of the AES block packer
`timescale 1ns/1ps
interface aes_block_packer_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic [127:0]     key_in;
  logic             key_load;
  logic [127:0]     data_out;
  logic [127:0]     key_out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] blk_count;

  modport master (
    output in_byte, in_valid, abort, key_in, key_load, out_ready,
    input  in_ready, data_out, key_out, out_valid, blk_count
  );

  modport slave (
    input  in_byte, in_valid, abort, key_in, key_load, out_ready,
    output in_ready, data_out, key_out, out_valid, blk_count
  );
endinterface

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs 16 stream bytes plus the active key into a held 128-bit block
`timescale 1ns/1ps
module aes_block_packer #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  aes_block_packer_if.slave bus
);
  logic [119:0]     acc;
  logic [3:0]       cnt;
  logic [127:0]     key_reg;
  logic [127:0]     data_q;
  logic [127:0]     key_q;
  logic             valid_q;
  logic [CNT_W-1:0] blk_q;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic             complete;

  // Only the 16th byte needs the output slot, so earlier bytes keep flowing under a stall.
  assign in_ready = !bus.abort && ((cnt != 4'd15) || !valid_q || bus.out_ready);
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = valid_q && bus.out_ready;
  assign complete = in_xfer && (cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      key_reg <= '0;
      data_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      blk_q   <= '0;
    end else begin
      if (bus.key_load) begin
        key_reg <= bus.key_in;
      end

      if (bus.abort) begin
        acc <= '0;
        cnt <= '0;
      end else if (complete) begin
        acc    <= '0;
        cnt    <= '0;
        data_q <= {acc, bus.in_byte};
        // A key loaded in the completing cycle already applies to this block.
        key_q  <= bus.key_load ? bus.key_in : key_reg;
      end else if (in_xfer) begin
        acc <= {acc[111:0], bus.in_byte};
        cnt <= cnt + 4'd1;
      end

      if (complete) begin
        valid_q <= 1'b1;
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end

      if (out_xfer) begin
        blk_q <= blk_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.data_out  = data_q;
  assign bus.key_out   = key_q;
  assign bus.out_valid = valid_q;
  assign bus.blk_count = blk_q;
endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - randomized self-checking bench for aes_block_packer
`timescale 1ns/1ps
module tb_aes_block_packer;
  logic clk;
  logic rst;

  aes_block_packer_if #(.CNT_W(16)) bus ();
  aes_block_packer_if #(.CNT_W(2))  bus2 ();

  aes_block_packer #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  aes_block_packer #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the block being packed, key register, held block, emitted count.
  logic [7:0]   m_bytes[$];
  logic [127:0] m_key;
  logic [127:0] m_data;
  logic [127:0] m_hkey;
  logic         m_valid;
  logic [15:0]  m_count;

  logic obs_ready;
  logic exp_ready;
  logic took;

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_DATA = 128'h00112233445566778899aabbccddeeff;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    m_key   = '0;
    m_data  = '0;
    m_hkey  = '0;
    m_valid = 1'b0;
    m_count = '0;
  endtask

  // One clock: drive at the falling edge, sample in_ready, advance the model at the rising edge.
  task automatic cycle(input logic [7:0] b, input logic v, input logic ord,
                       input logic ab, input logic kl, input logic [127:0] k);
    logic done;
    logic oxfer;
    @(negedge clk);
    bus.in_byte   = b;
    bus.in_valid  = v;
    bus.out_ready = ord;
    bus.abort     = ab;
    bus.key_load  = kl;
    bus.key_in    = k;
    #1;
    obs_ready = bus.in_ready;
    exp_ready = !ab && (m_bytes.size() != 15 || !m_valid || ord);
    @(posedge clk);
    took  = v && exp_ready;
    oxfer = m_valid && ord;
    done  = 1'b0;
    if (oxfer) m_count = m_count + 16'd1;
    if (ab) begin
      m_bytes.delete();
    end else if (took) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 16) begin
        for (int j = 0; j < 16; j++) m_data[127 - 8*j -: 8] = m_bytes[j];
        m_hkey = kl ? k : m_key;
        m_bytes.delete();
        done = 1'b1;
      end
    end
    if (done) m_valid = 1'b1;
    else if (oxfer) m_valid = 1'b0;
    if (kl) m_key = k;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_byte = '0; bus.in_valid = 1'b0; bus.abort = 1'b0;
    bus.key_in = '0; bus.key_load = 1'b0; bus.out_ready = 1'b0;
    bus2.in_byte = '0; bus2.in_valid = 1'b0; bus2.abort = 1'b0;
    bus2.key_in = '0; bus2.key_load = 1'b0; bus2.out_ready = 1'b0;
    model_reset();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
    checks++; if (bus.key_out !== 128'h0) begin errors++; $display("FAIL reset_key_out: got %h want 0", bus.key_out); end
    checks++; if (bus.blk_count !== 16'h0) begin errors++; $display("FAIL reset_blk_count: got %h want 0", bus.blk_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fips();
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, FIPS_KEY);
    for (int i = 0; i < 16; i++) begin
      cycle(8'(i * 17), 1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL fips_in_ready[%0d]: got %b want 1", i, obs_ready); end
      checks++; if (bus.out_valid !== (i == 15)) begin errors++; $display("FAIL fips_out_valid[%0d]: got %b want %b", i, bus.out_valid, (i == 15)); end
    end
    checks++; if (bus.data_out !== FIPS_DATA) begin errors++; $display("FAIL fips_data: got %h want %h", bus.data_out, FIPS_DATA); end
    checks++; if (bus.key_out !== FIPS_KEY) begin errors++; $display("FAIL fips_key: got %h want %h", bus.key_out, FIPS_KEY); end
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (bus.blk_count !== 16'd1) begin errors++; $display("FAIL fips_blk_count: got %0d want 1", bus.blk_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fips_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0]   bytes[32];
    logic [127:0] exp_blk;
    logic [15:0]  cnt0;
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom());
    cnt0 = m_count;
    for (int i = 0; i < 31; i++) begin
      cycle(bytes[i], 1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 1", i, obs_ready); end
      if (i >= 15) begin
        for (int j = 0; j < 16; j++) exp_blk[127 - 8*j -: 8] = bytes[j];
        checks++; if (bus.data_out !== exp_blk || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, bus.out_valid, bus.data_out, exp_blk);
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      cycle(bytes[31], 1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: got %b want 0", s, obs_ready); end
    end
    cycle(bytes[31], 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", obs_ready); end
    for (int j = 0; j < 16; j++) exp_blk[127 - 8*j -: 8] = bytes[16 + j];
    checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== exp_blk) begin
      errors++; $display("FAIL bp_second: got %b/%h want 1/%h", bus.out_valid, bus.data_out, exp_blk);
    end
    checks++; if (bus.blk_count !== cnt0 + 16'd1) begin errors++; $display("FAIL bp_count: got %0d want %0d", bus.blk_count, cnt0 + 16'd1); end
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (bus.blk_count !== cnt0 + 16'd2) begin errors++; $display("FAIL bp_count2: got %0d want %0d", bus.blk_count, cnt0 + 16'd2); end
  endtask

  task automatic test_abort();
    logic [127:0] exp_blk;
    for (int i = 0; i < 7; i++) cycle(8'($urandom()), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(8'hee, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", obs_ready); end
    for (int i = 0; i < 16; i++) cycle(8'(8'h10 + i), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_blk = 128'h101112131415161718191a1b1c1d1e1f;
    checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== exp_blk) begin
      errors++; $display("FAIL abort_data: got %b/%h want 1/%h", bus.out_valid, bus.data_out, exp_blk);
    end
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_key_race();
    logic [127:0] ka, kb, kc;
    ka = rnd128(); kb = rnd128(); kc = rnd128();
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ka);
    for (int i = 0; i < 15; i++) cycle(8'($urandom()), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(8'($urandom()), 1'b1, 1'b1, 1'b0, 1'b1, kb);
    checks++; if (bus.key_out !== kb) begin errors++; $display("FAIL key_same_cycle: got %h want %h", bus.key_out, kb); end
    checks++; if (bus.data_out !== m_data) begin errors++; $display("FAIL key_race_data: got %h want %h", bus.data_out, m_data); end
    for (int i = 0; i < 16; i++) cycle(8'($urandom()), 1'b1, 1'b1, 1'b0, (i == 4), kc);
    checks++; if (bus.key_out !== kc) begin errors++; $display("FAIL key_mid_block: got %h want %h", bus.key_out, kc); end
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    logic [7:0]   bytes[16];
    logic [127:0] exp_blk;
    for (int i = 0; i < 16; i++) cycle(8'($urandom()), 1'b1, 1'b0, 1'b0, 1'b1, rnd128());
    for (int i = 0; i < 8; i++) cycle(8'($urandom()), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_held: got %b want 1", bus.out_valid); end
    @(negedge clk);
    bus.in_byte = 8'h5a; bus.in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out !== 128'h0 || bus.key_out !== 128'h0) begin
      errors++; $display("FAIL rmid_data_key: got %h/%h want 0/0", bus.data_out, bus.key_out);
    end
    checks++; if (bus.blk_count !== 16'h0) begin errors++; $display("FAIL rmid_blk_count: got %0d want 0", bus.blk_count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom());
      cycle(bytes[i], 1'b1, 1'b1, 1'b0, 1'b0, '0);
    end
    for (int j = 0; j < 16; j++) exp_blk[127 - 8*j -: 8] = bytes[j];
    checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== exp_blk || bus.key_out !== 128'h0) begin
      errors++; $display("FAIL rmid_after: got %b/%h/%h want 1/%h/0", bus.out_valid, bus.data_out, bus.key_out, exp_blk);
    end
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      cycle(8'($urandom()), ($urandom_range(3) != 0), ($urandom_range(2) != 0),
            ($urandom_range(39) == 0), ($urandom_range(24) == 0), rnd128());
      checks++;
      if (obs_ready !== exp_ready || bus.out_valid !== m_valid || bus.data_out !== m_data ||
          bus.key_out !== m_hkey || bus.blk_count !== m_count) begin
        errors++;
        if (bad < 5) $display("FAIL random[%0d]: got rdy=%b v=%b d=%h c=%0d want rdy=%b v=%b d=%h c=%0d",
                              n, obs_ready, bus.out_valid, bus.data_out, bus.blk_count,
                              exp_ready, m_valid, m_data, m_count);
        bad++;
      end
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0]   seen[$];
    logic [1:0]   last;
    logic [127:0] exp_blk;
    int           k;
    last = bus2.blk_count;
    for (int i = 1; i <= 81; i++) begin
      @(negedge clk);
      bus2.out_ready = 1'b1;
      bus2.in_valid  = (i <= 80);
      bus2.in_byte   = 8'(i - 1);
      @(posedge clk);
      #1;
      checks++; if (bus2.out_valid !== (i % 16 == 0)) begin
        errors++; $display("FAIL wrap_valid[%0d]: got %b want %b", i, bus2.out_valid, (i % 16 == 0));
      end
      checks++; if (bus2.blk_count !== 2'((i - 1) / 16)) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, bus2.blk_count, 2'((i - 1) / 16));
      end
      if (i % 16 == 0) begin
        k = i / 16 - 1;
        for (int j = 0; j < 16; j++) exp_blk[127 - 8*j -: 8] = 8'(16*k + j);
        checks++; if (bus2.data_out !== exp_blk) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, bus2.data_out, exp_blk); end
      end
      if (bus2.blk_count !== last) begin
        seen.push_back(bus2.blk_count);
        last = bus2.blk_count;
      end
    end
    bus2.in_valid = 1'b0;
    checks++; if (seen.size() != 5) begin errors++; $display("FAIL wrap_seq_len: got %0d want 5", seen.size()); end
    else begin
      checks++; if (seen[0] !== 2'd1 || seen[1] !== 2'd2 || seen[2] !== 2'd3 || seen[3] !== 2'd0 || seen[4] !== 2'd1) begin
        errors++; $display("FAIL wrap_seq: got %0d,%0d,%0d,%0d,%0d want 1,2,3,0,1", seen[0], seen[1], seen[2], seen[3], seen[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_abort();
    test_key_race();
    test_reset_mid();
    test_random();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
